// File: rtl/alu_exec_seq.sv
// Execution sequencer around an external combinational ALU: holds Y/B operands,
// captures single-cycle results into Z, and runs 32-step signed MUL/DIV itself.
module alu_exec_seq #(
  parameter logic [3:0] OP_MUL = 4'hA,
  parameter logic [3:0] OP_DIV = 4'hB
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] bus_in,
  input  logic        y_in,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] b_in,
  input  logic [31:0] alu_comb_in,
  output logic [31:0] y_out,
  output logic [31:0] b_out,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] z_high,
  output logic [31:0] z_low
);

  // state  | meaning
  // S_IDLE | waiting for start; Y may be loaded
  // S_EVAL | capture external ALU result (or divide-by-zero pattern)
  // S_ITER | 32 shift-add / restoring-divide steps on magnitudes
  // S_SIGN | apply operand signs, load Z
  // S_DONE | done pulse, then back to idle
  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_ITER, S_SIGN, S_DONE} state_t;

  localparam int N_ITER = 32;

  state_t      state_q, state_d;
  logic [31:0] y_q, y_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] mag_q, mag_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;
  logic [31:0] z_high_q, z_high_d;
  logic [31:0] z_low_q, z_low_d;

  logic [31:0] y_eff;
  logic [32:0] sum33;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mag_d    = mag_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dbz_d    = dbz_q;
    z_high_d = z_high_q;
    z_low_d  = z_low_q;
    done_d   = 1'b0;
    y_eff    = y_in ? bus_in : y_q;
    sum33    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_q} : 33'd0);
    rem_sh   = {acc_hi_q, acc_lo_q[31]};
    rem_ge   = rem_sh >= {1'b0, mag_q};
    prod     = {acc_hi_q, acc_lo_q};
    quo      = acc_lo_q;
    rem      = acc_hi_q;

    case (state_q)
      S_IDLE: begin
        if (y_in) y_d = bus_in;
        if (start) begin
          op_d     = op;
          b_d      = b_in;
          dbz_d    = 1'b0;
          cnt_d    = 5'd0;
          sign_a_d = y_eff[31];
          sign_b_d = b_in[31];
          acc_hi_d = 32'd0;
          // -2^31 negates to itself, which reads correctly as unsigned 2^31
          acc_lo_d = y_eff[31] ? (32'd0 - y_eff) : y_eff;
          mag_d    = b_in[31] ? (32'd0 - b_in) : b_in;
          if (op == OP_MUL || (op == OP_DIV && b_in != 32'd0)) state_d = S_ITER;
          else                                                   state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (op_q == OP_DIV) begin
          z_low_d  = 32'hFFFF_FFFF;
          z_high_d = y_q;
          dbz_d    = 1'b1;
        end else begin
          z_low_d  = alu_comb_in;
          z_high_d = 32'd0;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_ITER: begin
        if (op_q == OP_MUL) begin
          acc_hi_d = sum33[32:1];
          acc_lo_d = {sum33[0], acc_lo_q[31:1]};
        end else begin
          acc_hi_d = rem_ge ? (rem_sh[31:0] - mag_q) : rem_sh[31:0];
          acc_lo_d = {acc_lo_q[30:0], rem_ge};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(N_ITER - 1)) state_d = S_SIGN;
      end
      S_SIGN: begin
        if (op_q == OP_MUL) begin
          if (sign_a_q ^ sign_b_q) prod = 64'd0 - prod;
          z_high_d = prod[63:32];
          z_low_d  = prod[31:0];
        end else begin
          if (sign_a_q ^ sign_b_q) quo = 32'd0 - quo;
          if (sign_a_q)            rem = 32'd0 - rem;
          z_high_d = rem;
          z_low_d  = quo;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= S_IDLE;
      y_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mag_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      z_high_q <= '0;
      z_low_q  <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mag_q    <= mag_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      z_high_q <= z_high_d;
      z_low_q  <= z_low_d;
    end
  end

  assign y_out       = y_q;
  assign b_out       = b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign z_high      = z_high_q;
  assign z_low       = z_low_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq; the external ALU is modelled as rotate-right.
module tb_alu_exec_seq;

  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_DIV = 4'hB;
  localparam logic [3:0] OP_ROR = 4'h5;

  logic        clk = 1'b0;
  logic        clear;
  logic [31:0] bus_in;
  logic        y_in;
  logic        start;
  logic [3:0]  op;
  logic [31:0] b_in;
  logic [31:0] alu_comb_in;
  logic [31:0] y_out;
  logic [31:0] b_out;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] z_high;
  logic [31:0] z_low;

  int checks   = 0;
  int failures = 0;

  alu_exec_seq #(.OP_MUL(OP_MUL), .OP_DIV(OP_DIV)) dut (
    .clk(clk), .clear(clear), .bus_in(bus_in), .y_in(y_in), .start(start),
    .op(op), .b_in(b_in), .alu_comb_in(alu_comb_in), .y_out(y_out),
    .b_out(b_out), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .z_high(z_high), .z_low(z_low)
  );

  always #5 clk = ~clk;

  logic [4:0] sh;
  assign sh          = b_out[4:0];
  assign alu_comb_in = (y_out >> sh) | (y_out << (6'd32 - {1'b0, sh}));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one operation from IDLE; cycle 1 is the cycle after the start edge.
  task automatic run_op(input string tag, input logic [31:0] y, input logic [3:0] opc,
                        input logic [31:0] b, input logic [63:0] exp_z,
                        input int exp_cyc, input bit exp_dbz, input bit disturb);
    logic [63:0] prev_z;
    int first, pulses;
    bit zchg, unstable;
    prev_z = {z_high, z_low};
    first = 0; pulses = 0; zchg = 0; unstable = 0;
    @(negedge clk);
    bus_in = y; y_in = 1'b1; start = 1'b1; op = opc; b_in = b;
    @(negedge clk);
    y_in = 1'b0; start = 1'b0;
    for (int n = 1; n <= exp_cyc + 3; n++) begin
      if (n > 1) @(negedge clk);
      if (disturb && n == 5) begin
        bus_in = 32'h5; y_in = 1'b1; start = 1'b1; op = OP_ROR; b_in = 32'h9;
      end else begin
        y_in = 1'b0; start = 1'b0;
      end
      if (done) begin
        pulses++;
        if (first == 0) first = n;
      end
      if (first == 0 && {z_high, z_low} !== prev_z) zchg = 1'b1;
      if (busy && (y_out !== y || b_out !== b)) unstable = 1'b1;
    end
    chk({tag, " done_cycle"}, 64'(first), 64'(exp_cyc));
    chk({tag, " done_pulses"}, 64'(pulses), 64'd1);
    chk({tag, " z"}, {z_high, z_low}, exp_z);
    chk({tag, " z_early_change"}, 64'(zchg), 64'd0);
    chk({tag, " operands_unstable"}, 64'(unstable), 64'd0);
    chk({tag, " y_out"}, 64'(y_out), 64'(y));
    chk({tag, " b_out"}, 64'(b_out), 64'(b));
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int pulses;
    clear = 1'b1; bus_in = '0; y_in = 1'b0; start = 1'b0; op = '0; b_in = '0;
    repeat (2) @(negedge clk);
    chk("reset z", {z_high, z_low}, 64'd0);
    chk("reset y_b", {y_out, b_out}, 64'd0);
    chk("reset flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    clear = 1'b0;

    run_op("ror", 32'h0000_00F1, OP_ROR, 32'd4, {32'h0, 32'h1000_000F}, 2, 1'b0, 1'b0);
    chk("ror count", 64'(b_out[4:0]), 64'd4);
    run_op("mul_neg", 32'hFFFF_FFFD, OP_MUL, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 34, 1'b0, 1'b0);
    run_op("mul_min", 32'h8000_0000, OP_MUL, 32'h8000_0000, {32'h4000_0000, 32'h0}, 34, 1'b0, 1'b0);
    run_op("div_neg", 32'hFFFF_FFEF, OP_DIV, 32'd5, {32'hFFFF_FFFE, 32'hFFFF_FFFD}, 34, 1'b0, 1'b0);
    run_op("div_min", 32'h8000_0000, OP_DIV, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34, 1'b0, 1'b0);
    run_op("div_pos", 32'd100, OP_DIV, 32'd7, {32'd2, 32'd14}, 34, 1'b0, 1'b0);
    run_op("div_negb", 32'd7, OP_DIV, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 34, 1'b0, 1'b0);
    run_op("div_zero", 32'h0000_1234, OP_DIV, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 2, 1'b1, 1'b0);
    run_op("dbz_clr", 32'h0000_00F1, OP_ROR, 32'd8, {32'h0, 32'hF100_0000}, 2, 1'b0, 1'b0);

    // abort a multiply with clear during cycle 10
    @(negedge clk);
    bus_in = 32'd3; y_in = 1'b1; start = 1'b1; op = OP_MUL; b_in = 32'd5;
    @(negedge clk);
    y_in = 1'b0; start = 1'b0;
    pulses = done ? 1 : 0;
    for (int n = 2; n <= 10; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort z", {z_high, z_low}, 64'd0);
    chk("abort y_b", {y_out, b_out}, 64'd0);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort no_done", 64'(pulses), 64'd0);

    run_op("mul_fresh", 32'h0000_1234, OP_MUL, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'hFFFF_DB98}, 34, 1'b0, 1'b0);
    run_op("mul_ignore", 32'd100, OP_MUL, 32'hFFFF_FFFD, {32'hFFFF_FFFF, 32'hFFFF_FED4}, 34, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
